// File: rtl/pipe_cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// The group width is fixed at 4 bits; the op enum selects add or subtract.
package pipe_cla_pkg;

   localparam int CLA_GRP = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Carry out of a lookahead group from its propagate/generate pair.
   function automatic logic groupCarry(input logic p, input logic g, input logic ci);
      return g | (p & ci);
   endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate,
// so the enclosing slice can ripple carries group to group.
module cla_group4
   import pipe_cla_pkg::*;
(
   input  logic [CLA_GRP-1:0] i_a,
   input  logic [CLA_GRP-1:0] i_b,
   input  logic               i_ci,
   output logic [CLA_GRP-1:0] o_s,
   output logic               o_p,
   output logic               o_g
);

   logic [CLA_GRP-1:0] w_p;
   logic [CLA_GRP-1:0] w_g;
   logic [CLA_GRP-1:0] w_c;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Every internal carry is a flat two-level function of the group inputs.
   assign w_c[0] = i_ci;
   assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_ci);

   assign o_s = w_p ^ w_c;
   assign o_p = &w_p;
   assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined CLA adder/subtractor: one carry slice per stage, global-advance flow control.
// Define PIPE_CLA_OVF_EN to add the registered signed-overflow output ovf.
module pipe_cla_adder
   import pipe_cla_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef PIPE_CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SLICE_W = WIDTH / STAGES;
   localparam int GPS     = SLICE_W / CLA_GRP;
   localparam int NUM_GRP = WIDTH / CLA_GRP;

   if ((STAGES < 1) || (WIDTH % STAGES != 0) || (SLICE_W % CLA_GRP != 0) || (SLICE_W == 0)) begin : g_badParams
      $error("pipe_cla_adder: WIDTH must split into STAGES equal slices that are multiples of 4 bits");
   end

   op_e              w_op;
   logic [WIDTH-1:0] w_bIn;
   logic             w_cIn;
   logic             w_advance;

   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];
   logic [STAGES-1:0] r_vld;

   logic [WIDTH-1:0] w_opA     [STAGES];
   logic [WIDTH-1:0] w_opB     [STAGES];
   logic             w_sliceCi [STAGES];
   logic [STAGES-1:0] w_sliceCo;
   logic [WIDTH-1:0] w_grpSum;
   logic [NUM_GRP-1:0] w_grpP;
   logic [NUM_GRP-1:0] w_grpG;
   logic [NUM_GRP-1:0] w_grpCi;
   logic [NUM_GRP-1:0] w_grpCo;

   // Subtraction is a + ~b + 1; the external carry-in only matters when adding.
   assign w_op      = op_e'(sub);
   assign w_bIn     = (w_op == OP_SUB) ? ~b : b;
   assign w_cIn     = (w_op == OP_SUB) ? 1'b1 : cin;
   assign w_advance = !r_vld[STAGES-1] || out_ready;
   assign in_ready  = w_advance && !rst;

   for (genvar k = 0; k < STAGES; k++) begin : g_stageSrc
      if (k == 0) begin : g_first
         assign w_opA[k]     = a;
         assign w_opB[k]     = w_bIn;
         assign w_sliceCi[k] = w_cIn;
      end else begin : g_rest
         assign w_opA[k]     = r_a[k-1];
         assign w_opB[k]     = r_b[k-1];
         assign w_sliceCi[k] = r_c[k-1];
      end
      assign w_sliceCo[k] = w_grpCo[k*GPS + GPS - 1];
   end

   // Each group draws its operands from the stage that owns its slice.
   for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
      localparam int K = g / GPS;
      if (g % GPS == 0) begin : g_sliceHead
         assign w_grpCi[g] = w_sliceCi[K];
      end else begin : g_sliceBody
         assign w_grpCi[g] = w_grpCo[g-1];
      end
      cla_group4 u_grp (
         .i_a  (w_opA[K][g*CLA_GRP +: CLA_GRP]),
         .i_b  (w_opB[K][g*CLA_GRP +: CLA_GRP]),
         .i_ci (w_grpCi[g]),
         .o_s  (w_grpSum[g*CLA_GRP +: CLA_GRP]),
         .o_p  (w_grpP[g]),
         .o_g  (w_grpG[g])
      );
      assign w_grpCo[g] = groupCarry(w_grpP[g], w_grpG[g], w_grpCi[g]);
   end

   function automatic logic [WIDTH-1:0] sliceMask(input int k);
      return WIDTH'({SLICE_W{1'b1}}) << (k * SLICE_W);
   endfunction

   // The whole pipe moves together; a stalled consumer freezes every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
         end
      end else if (w_advance) begin
         r_vld[0] <= in_valid;
         r_a[0]   <= a;
         r_b[0]   <= w_bIn;
         r_sum[0] <= w_grpSum & sliceMask(0);
         r_c[0]   <= w_sliceCo[0];
         for (int k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_a[k]   <= r_a[k-1];
            r_b[k]   <= r_b[k-1];
            r_sum[k] <= (r_sum[k-1] & ~sliceMask(k)) | (w_grpSum & sliceMask(k));
            r_c[k]   <= w_sliceCo[k];
         end
      end
   end

`ifdef PIPE_CLA_OVF_EN
   logic r_ovf;

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         r_ovf <= w_opA[STAGES-1][WIDTH-1] ^ w_opB[STAGES-1][WIDTH-1]
                ^ w_grpSum[WIDTH-1] ^ w_sliceCo[STAGES-1];
      end
   end

   assign ovf = r_ovf;
`endif

   assign sum       = r_sum[STAGES-1];
   assign cout      = r_c[STAGES-1];
   assign out_valid = r_vld[STAGES-1];

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: directed table, corner sequences and random traffic
// against an arithmetic reference model. Honours PIPE_CLA_OVF_EN when defined.
module tb_pipe_cla_adder;

   localparam int W = 64;
   localparam int S = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         out_valid;
   logic         out_ready;
`ifdef PIPE_CLA_OVF_EN
   logic         ovf;
`endif

   int nVec  = 0;
   int nMiss = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] expSum;
      logic         expCout;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      res_t         exp;
   } op_t;

   op_t  opQ[$];
   res_t expQ[$];
   vec_t vecs[8];
   logic [5:0] readyPat;

   pipe_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef PIPE_CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: wide unsigned arithmetic for sum/cout, exact signed result for overflow.
   function automatic res_t refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rc, input logic rs);
      res_t r;
      logic [W:0] full;
      logic signed [W+1:0] sres;
      if (rs) begin
         r.sum  = ra - rb;
         r.cout = (ra >= rb);
         sres   = $signed({{2{ra[W-1]}}, ra}) - $signed({{2{rb[W-1]}}, rb});
      end else begin
         full   = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         r.sum  = full[W-1:0];
         r.cout = full[W];
         sres   = $signed({{2{ra[W-1]}}, ra}) + $signed({{2{rb[W-1]}}, rb})
                + $signed({{(W+1){1'b0}}, rc});
      end
      r.ovf = !((sres[W+1:W-1] == 3'b000) || (sres[W+1:W-1] == 3'b111));
      return r;
   endfunction

   function automatic op_t mkOp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                input logic rc, input logic rs);
      op_t o;
      o.a = ra; o.b = rb; o.cin = rc; o.sub = rs;
      o.exp = refModel(ra, rb, rc, rs);
      return o;
   endfunction

   function automatic op_t mkVecOp(input vec_t v);
      op_t o;
      o = mkOp(v.a, v.b, v.cin, v.sub);
      o.exp.sum  = v.expSum;
      o.exp.cout = v.expCout;
      return o;
   endfunction

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return {1'b1, {(W-1){1'b0}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic op_t randOp();
      return mkOp(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input op_t op);
      in_valid = v;
      a        = op.a;
      b        = op.b;
      cin      = op.cin;
      sub      = op.sub;
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drains opQ through the DUT, scoring every delivered result in order.
   task automatic runOps(input int readyMode, input bit gaps, input bit chkB2b);
      int cyc = 0;
      int lastDeliv = -1;
      bit prevStall = 1'b0;
      logic [W-1:0] prevSum = '0;
      op_t idle;
      op_t op;
      res_t e;
      idle = randOp();
      while ((opQ.size() > 0 || expQ.size() > 0) && cyc < 3000) begin
         if (opQ.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            applyStimulus(1'b1, opQ[0]);
         end else begin
            idle.a = {$urandom, $urandom};
            applyStimulus(1'b0, idle);
         end
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = readyPat[cyc % 6];
            default: out_ready = ($urandom_range(0, 2) != 0);
         endcase
         #1;
         if (prevStall) begin
            checkOutput("stallHoldValid", W'(out_valid), W'(1'b1));
            checkOutput("stallHoldSum", sum, prevSum);
         end
         if (out_valid && !out_ready) checkOutput("stallReady", W'(in_ready), W'(1'b0));
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               nVec++;
               nMiss++;
               $display("[TB] FAIL extraResult: got sum %0h, expected no result", sum);
            end else begin
               e = expQ.pop_front();
               checkOutput("sum", sum, e.sum);
               checkOutput("cout", W'(cout), W'(e.cout));
`ifdef PIPE_CLA_OVF_EN
               checkOutput("ovf", W'(ovf), W'(e.ovf));
`endif
               if (chkB2b && lastDeliv >= 0) checkOutput("b2bSpacing", W'(cyc), W'(lastDeliv + 1));
               lastDeliv = cyc;
            end
         end
         if (in_valid && in_ready) begin
            op = opQ.pop_front();
            expQ.push_back(op.exp);
         end
         prevStall = out_valid && !out_ready;
         prevSum   = sum;
         stepCycle();
         cyc++;
      end
      in_valid = 1'b0;
      if (opQ.size() > 0 || expQ.size() > 0) begin
         nVec++;
         nMiss++;
         $display("[TB] FAIL timeout: got %0d results pending, expected 0", expQ.size() + opQ.size());
         opQ.delete();
         expQ.delete();
      end
      // Nothing may emerge once every expected result has been delivered.
      out_ready = 1'b1;
      for (int i = 0; i < S + 2; i++) begin
         #1;
         checkOutput("noExtra", W'(out_valid), W'(1'b0));
         stepCycle();
      end
   endtask

   initial begin
      int lat;
      int spurious;
      op_t op;

      vecs[0] = '{64'd2,   64'd5,   1'b0, 1'b0, 64'd7,   1'b0};
      vecs[1] = '{64'd20,  64'd20,  1'b1, 1'b0, 64'd41,  1'b0};
      vecs[2] = '{64'd75,  64'd75,  1'b1, 1'b0, 64'd151, 1'b0};
      vecs[3] = '{64'd128, 64'd128, 1'b0, 1'b0, 64'd256, 1'b0};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1};
      vecs[5] = '{64'd5,   64'd7,   1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[6] = '{64'd7,   64'd5,   1'b0, 1'b1, 64'd2,   1'b1};
      vecs[7] = '{64'd200, 64'd20,  1'b0, 1'b0, 64'd220, 1'b0};
      readyPat = 6'b101001;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("rstOutValid", W'(out_valid), W'(1'b0));
      checkOutput("rstInReady", W'(in_ready), W'(1'b0));
      checkOutput("rstSum", sum, '0);
      checkOutput("rstCout", W'(cout), W'(1'b0));
`ifdef PIPE_CLA_OVF_EN
      checkOutput("rstOvf", W'(ovf), W'(1'b0));
`endif
      rst = 1'b0;
      #1;
      checkOutput("readyAfterRst", W'(in_ready), W'(1'b1));

      // Single op latency: valid must appear exactly S cycles after acceptance.
      out_ready = 1'b1;
      applyStimulus(1'b1, mkVecOp(vecs[0]));
      #1;
      checkOutput("acceptReady", W'(in_ready), W'(1'b1));
      stepCycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         stepCycle();
         lat++;
      end
      checkOutput("latency", W'(lat), W'(S));
      checkOutput("latSum", sum, 64'd7);
      checkOutput("latCout", W'(cout), W'(1'b0));
      stepCycle();
      checkOutput("latDrained", W'(out_valid), W'(1'b0));

      for (int i = 1; i < 4; i++) opQ.push_back(mkVecOp(vecs[i]));
      runOps(0, 1'b0, 1'b1);

      for (int i = 4; i < 7; i++) begin
         opQ.push_back(mkVecOp(vecs[i]));
         runOps(0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 6; i++) opQ.push_back(randOp());
      runOps(1, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++) opQ.push_back(randOp());
      runOps(2, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) opQ.push_back(randOp());
      runOps(0, 1'b1, 1'b0);

      // Reset with three operations in flight and a transfer offered on the reset edge.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, mkOp(64'(i + 10), 64'd1, 1'b0, 1'b0));
         stepCycle();
      end
      rst = 1'b1;
      applyStimulus(1'b1, mkOp(64'd99, 64'd1, 1'b0, 1'b0));
      #1;
      checkOutput("rstBlocksReady", W'(in_ready), W'(1'b0));
      stepCycle();
      rst = 1'b0;
      in_valid = 1'b0;
      checkOutput("midRstValid", W'(out_valid), W'(1'b0));
      checkOutput("midRstSum", sum, '0);
      spurious = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) spurious++;
         stepCycle();
      end
      checkOutput("staleResults", W'(spurious), '0);
      opQ.push_back(mkVecOp(vecs[7]));
      runOps(0, 1'b0, 1'b0);

      op = mkOp(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      op.exp.sum  = 64'h8000_0000_0000_0000;
      op.exp.cout = 1'b0;
      op.exp.ovf  = 1'b1;
      opQ.push_back(op);
      runOps(0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
